// File: rtl/stopwatch_bcd.sv
// Stopwatch core: button conditioning, prescaler, IDLE/RUN/STOP/LAP control,
// cascaded BCD decades with a frozen lap display and per-digit 7-segment decode.
module stopwatch_bcd #(
    parameter int CLK_DIV   = 500000,
    parameter int NB_DIGITS = 4,
    parameter bit SEG_POL   = 1'b1
) (
    input  logic                   ClkIn,
    input  logic                   Rst,
    input  logic                   StartStop,
    input  logic                   Lap,
    input  logic                   Clear,
    output logic [4*NB_DIGITS-1:0] Bcd,
    output logic [7*NB_DIGITS-1:0] Seg,
    output logic                   Running,
    output logic                   Ovf
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP,
        LAP
    } state_t;

    state_t stateQ;
    state_t stateD;

    logic [2:0] ssSync;
    logic [2:0] lapSync;
    logic [2:0] clrSync;
    logic       ssPress;
    logic       lapPress;
    logic       clrPress;

    logic [DIV_W-1:0] divCnt;
    logic             tick;
    logic             latchLap;

    logic [NB_DIGITS-1:0][3:0] digitQ;
    logic [NB_DIGITS-1:0][3:0] lapQ;
    logic [NB_DIGITS-1:0]      carry;
    logic                      wrap;

    // Three-flop chains: bit 0 = s1, bit 1 = s2, bit 2 = s3.
    always_ff @(posedge ClkIn or posedge Rst) begin
        if (Rst) begin
            ssSync  <= '0;
            lapSync <= '0;
            clrSync <= '0;
        end else begin
            ssSync  <= {ssSync[1:0], StartStop};
            lapSync <= {lapSync[1:0], Lap};
            clrSync <= {clrSync[1:0], Clear};
        end
    end

    always_comb begin
        ssPress  = ssSync[1] & ~ssSync[2];
        lapPress = lapSync[1] & ~lapSync[2];
        clrPress = clrSync[1] & ~clrSync[2];
    end

    always_ff @(posedge ClkIn or posedge Rst) begin
        if (Rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        latchLap = 1'b0;
        Running  = (stateQ == RUN) || (stateQ == LAP);
        if (clrPress) begin
            stateD = IDLE;
        end else if (ssPress) begin
            case (stateQ)
                IDLE:    stateD = RUN;
                RUN:     stateD = STOP;
                STOP:    stateD = RUN;
                LAP:     stateD = STOP;
                default: stateD = IDLE;
            endcase
        end else if (lapPress) begin
            case (stateQ)
                RUN: begin
                    stateD   = LAP;
                    latchLap = 1'b1;
                end
                LAP:     stateD = RUN;
                default: stateD = stateQ;
            endcase
        end
    end

    // Prescaler only advances while Running; in STOP it holds so resume is exact.
    always_comb begin
        tick = Running && (divCnt == DIV_LAST);
    end

    always_ff @(posedge ClkIn or posedge Rst) begin
        if (Rst) begin
            divCnt <= '0;
        end else if (clrPress) begin
            divCnt <= '0;
        end else if (Running) begin
            divCnt <= tick ? '0 : divCnt + 1'b1;
        end
    end

    // carry[i]: tick arrives at digit i (all lower digits are 9).
    always_comb begin
        logic c;
        c     = tick;
        carry = '0;
        for (int unsigned i = 0; i < NB_DIGITS; i++) begin
            carry[i] = c;
            c        = c && (digitQ[i] == 4'd9);
        end
        wrap = c;
    end

    always_ff @(posedge ClkIn or posedge Rst) begin
        if (Rst) begin
            digitQ <= '0;
        end else if (clrPress) begin
            digitQ <= '0;
        end else begin
            for (int unsigned i = 0; i < NB_DIGITS; i++) begin
                if (carry[i]) begin
                    digitQ[i] <= (digitQ[i] == 4'd9) ? 4'd0 : digitQ[i] + 4'd1;
                end
            end
        end
    end

    // Latched from the pre-increment value when a tick coincides with the press.
    always_ff @(posedge ClkIn or posedge Rst) begin
        if (Rst) begin
            lapQ <= '0;
        end else if (clrPress) begin
            lapQ <= '0;
        end else if (latchLap) begin
            lapQ <= digitQ;
        end
    end

    always_ff @(posedge ClkIn or posedge Rst) begin
        if (Rst) begin
            Ovf <= 1'b0;
        end else if (clrPress) begin
            Ovf <= 1'b0;
        end else if (wrap) begin
            Ovf <= 1'b1;
        end
    end

    always_comb begin
        Bcd = (stateQ == LAP) ? lapQ : digitQ;
    end

    function automatic logic [6:0] segDecode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    always_comb begin
        Seg = '0;
        for (int unsigned i = 0; i < NB_DIGITS; i++) begin
            Seg[7*i +: 7] = SEG_POL ? segDecode(Bcd[4*i +: 4]) : ~segDecode(Bcd[4*i +: 4]);
        end
    end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd (CLK_DIV=4, 2 digits, both segment polarities):
// directed scenarios plus randomized button activity against an elapsed-tick model.
module tb_stopwatch_bcd;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss  = 1'b0;
    logic        lp  = 1'b0;
    logic        cl  = 1'b0;
    logic [7:0]  bcd, bcdN;
    logic [13:0] seg, segN;
    logic        run, runN, ovf, ovfN;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    stopwatch_bcd #(.CLK_DIV(CLK_DIV), .NB_DIGITS(2), .SEG_POL(1'b1)) dut (
        .ClkIn(clk), .Rst(rst), .StartStop(ss), .Lap(lp), .Clear(cl),
        .Bcd(bcd), .Seg(seg), .Running(run), .Ovf(ovf)
    );

    stopwatch_bcd #(.CLK_DIV(CLK_DIV), .NB_DIGITS(2), .SEG_POL(1'b0)) dutN (
        .ClkIn(clk), .Rst(rst), .StartStop(ss), .Lap(lp), .Clear(cl),
        .Bcd(bcdN), .Seg(segN), .Running(runN), .Ovf(ovfN)
    );

    logic [6:0] segTab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    // Model: elapsed value as an integer 0..99, a running flag and a frozen flag.
    // IDLE and STOP react identically to presses, so they need no distinction here.
    int mVal = 0, mLap = 0, mDiv = 0;
    bit mRun = 0, mFrz = 0, mOvf = 0;
    bit [2:0] hSs = '0, hLp = '0, hCl = '0;

    always @(posedge clk or posedge rst) begin
        bit pSs, pLp, pCl, tk, wasRun;
        if (rst) begin
            mVal = 0; mLap = 0; mDiv = 0; mRun = 0; mFrz = 0; mOvf = 0;
            hSs = '0; hLp = '0; hCl = '0;
        end else begin
            pSs = hSs[1] & ~hSs[2];
            pLp = hLp[1] & ~hLp[2];
            pCl = hCl[1] & ~hCl[2];
            hSs = {hSs[1:0], ss};
            hLp = {hLp[1:0], lp};
            hCl = {hCl[1:0], cl};
            wasRun = mRun;
            tk = mRun && (mDiv == CLK_DIV - 1);
            if (pCl) begin
                mVal = 0; mLap = 0; mDiv = 0; mRun = 0; mFrz = 0; mOvf = 0;
            end else begin
                if (pSs) begin
                    if (mRun) begin mRun = 0; mFrz = 0; end
                    else mRun = 1;
                end else if (pLp && mRun) begin
                    if (mFrz) mFrz = 0;
                    else begin mFrz = 1; mLap = mVal; end
                end
                if (wasRun) mDiv = (mDiv + 1) % CLK_DIV;
                if (tk) begin
                    if (mVal == 99) mOvf = 1;
                    mVal = (mVal + 1) % 100;
                end
            end
        end
    end

    function automatic logic [7:0] toBcd(input int v);
        return 8'((((v / 10) % 10) << 4) | (v % 10));
    endfunction

    function automatic int fromBcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] expBcd();
        return toBcd(mFrz ? mLap : mVal);
    endfunction

    function automatic logic [13:0] expSeg(input logic [7:0] b, input bit pol);
        logic [13:0] s;
        s = {segTab[b[7:4]], segTab[b[3:0]]};
        return pol ? s : ~s;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nTests++; if (bcd !== 8'h00) begin nFail++; $display("FAIL reset_bcd: got %h want 00", bcd); end
        nTests++; if (seg !== {7'h3F, 7'h3F}) begin nFail++; $display("FAIL reset_seg: got %b want %b", seg, {7'h3F, 7'h3F}); end
        nTests++; if (segN !== {7'h40, 7'h40}) begin nFail++; $display("FAIL reset_seg_pol0: got %b want %b", segN, {7'h40, 7'h40}); end
        nTests++; if (run !== 1'b0 || runN !== 1'b0) begin nFail++; $display("FAIL reset_running: got %b/%b want 0", run, runN); end
        nTests++; if (ovf !== 1'b0 || ovfN !== 1'b0) begin nFail++; $display("FAIL reset_ovf: got %b/%b want 0", ovf, ovfN); end
        nTests++; if (bcdN !== 8'h00) begin nFail++; $display("FAIL reset_bcd_pol0: got %h want 00", bcdN); end
        rst = 1'b0;
    endtask

    task automatic test_start();
        ss = 1'b1;
        @(negedge clk); ss = 1'b0;
        nTests++; if (run !== 1'b0) begin nFail++; $display("FAIL start_edge1: running %b want 0", run); end
        @(negedge clk);
        nTests++; if (run !== 1'b0) begin nFail++; $display("FAIL start_edge2: running %b want 0", run); end
        @(negedge clk);
        nTests++; if (run !== 1'b1) begin nFail++; $display("FAIL start_edge3: running %b want 1", run); end
        repeat (3) @(negedge clk);
        nTests++; if (bcd !== 8'h00) begin nFail++; $display("FAIL start_pretick: bcd %h want 00", bcd); end
        @(negedge clk);
        nTests++; if (bcd !== 8'h01) begin nFail++; $display("FAIL start_first_tick: bcd %h want 01", bcd); end
    endtask

    task automatic test_carry_wrap();
        repeat (98 * CLK_DIV) @(negedge clk);
        nTests++; if (bcd !== 8'h99) begin nFail++; $display("FAIL wrap_99: bcd %h want 99", bcd); end
        nTests++; if (ovf !== 1'b0) begin nFail++; $display("FAIL wrap_ovf_early: ovf %b want 0", ovf); end
        repeat (CLK_DIV - 1) @(negedge clk);
        nTests++; if (bcd !== 8'h99) begin nFail++; $display("FAIL wrap_hold99: bcd %h want 99", bcd); end
        @(negedge clk);
        nTests++; if (bcd !== 8'h00) begin nFail++; $display("FAIL wrap_00: bcd %h want 00", bcd); end
        nTests++; if (ovf !== 1'b1) begin nFail++; $display("FAIL wrap_ovf: ovf %b want 1", ovf); end
        cl = 1'b1;
        @(negedge clk); cl = 1'b0;
        repeat (2) @(negedge clk);
        nTests++; if (ovf !== 1'b0) begin nFail++; $display("FAIL clear_ovf: ovf %b want 0", ovf); end
        nTests++; if (run !== 1'b0) begin nFail++; $display("FAIL clear_running: running %b want 0", run); end
        repeat (8) @(negedge clk);
        nTests++; if (bcd !== 8'h00) begin nFail++; $display("FAIL clear_idle_bcd: bcd %h want 00", bcd); end
    endtask

    task automatic test_lap();
        ss = 1'b1;
        @(negedge clk); ss = 1'b0;
        repeat (2) @(negedge clk);
        repeat (12 * CLK_DIV) @(negedge clk);
        nTests++; if (bcd !== 8'h12) begin nFail++; $display("FAIL lap_pre: bcd %h want 12", bcd); end
        lp = 1'b1;
        @(negedge clk); lp = 1'b0;
        repeat (2) @(negedge clk);
        nTests++; if (bcd !== 8'h12 || run !== 1'b1) begin nFail++; $display("FAIL lap_enter: bcd %h run %b want 12 1", bcd, run); end
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            nTests++; if (bcd !== 8'h12) begin nFail++; $display("FAIL lap_frozen: cycle %0d bcd %h want 12", c, bcd); end
        end
        nTests++; if (expBcd() !== 8'h12 || mVal != 17) begin nFail++; $display("FAIL lap_model: model %h/%0d want 12/17", expBcd(), mVal); end
        lp = 1'b1;
        @(negedge clk); lp = 1'b0;
        repeat (2) @(negedge clk);
        nTests++; if (bcd !== 8'h17) begin nFail++; $display("FAIL lap_release: bcd %h want 17", bcd); end
    endtask

    task automatic test_stop_resume();
        logic [7:0] prev, held;
        bit seen;
        prev = bcd;
        seen = 0;
        for (int c = 0; c < 2 * CLK_DIV && !seen; c++) begin
            @(negedge clk);
            if (bcd !== prev) seen = 1;
        end
        nTests++; if (!seen) begin nFail++; $display("FAIL stop_tick_timeout: bcd %h never changed", bcd); end
        prev = bcd;
        repeat (CLK_DIV - 1) @(negedge clk);
        ss = 1'b1;
        @(negedge clk); ss = 1'b0;
        nTests++; if (bcd !== toBcd(fromBcd(prev) + 1)) begin nFail++; $display("FAIL stop_tick_before: bcd %h want %h", bcd, toBcd(fromBcd(prev) + 1)); end
        held = bcd;
        repeat (2) @(negedge clk);
        nTests++; if (run !== 1'b0) begin nFail++; $display("FAIL stop_state: running %b want 0", run); end
        repeat (50) @(negedge clk);
        nTests++; if (bcd !== held) begin nFail++; $display("FAIL stop_hold: bcd %h want %h", bcd, held); end
        ss = 1'b1;
        @(negedge clk); ss = 1'b0;
        repeat (2) @(negedge clk);
        nTests++; if (run !== 1'b1) begin nFail++; $display("FAIL resume_state: running %b want 1", run); end
        @(negedge clk);
        nTests++; if (bcd !== held) begin nFail++; $display("FAIL resume_early: bcd %h want %h", bcd, held); end
        @(negedge clk);
        nTests++; if (bcd !== toBcd(fromBcd(held) + 1)) begin nFail++; $display("FAIL resume_tick: bcd %h want %h", bcd, toBcd(fromBcd(held) + 1)); end
    endtask

    task automatic test_priority();
        logic [7:0] lapV;
        cl = 1'b1; ss = 1'b1;
        @(negedge clk); cl = 1'b0; ss = 1'b0;
        repeat (2) @(negedge clk);
        nTests++; if (run !== 1'b0 || bcd !== 8'h00) begin nFail++; $display("FAIL prio_clear: run %b bcd %h want 0 00", run, bcd); end
        repeat (6) @(negedge clk);
        nTests++; if (bcd !== 8'h00) begin nFail++; $display("FAIL prio_idle: bcd %h want 00", bcd); end
        ss = 1'b1;
        @(negedge clk); ss = 1'b0;
        repeat (2) @(negedge clk);
        lapV = 8'hFF;
        lp = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 3) lapV = bcd;
        end
        lp = 1'b0;
        nTests++; if (bcd !== lapV || run !== 1'b1) begin nFail++; $display("FAIL lap_hold_once: bcd %h run %b want %h 1", bcd, run, lapV); end
        nTests++; if (bcd !== expBcd()) begin nFail++; $display("FAIL lap_hold_model: bcd %h want %h", bcd, expBcd()); end
        lp = 1'b1;
        @(negedge clk); lp = 1'b0;
        repeat (10) @(negedge clk);
        nTests++; if (bcd !== expBcd()) begin nFail++; $display("FAIL lap_hold_release: bcd %h want %h", bcd, expBcd()); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        nTests++; if (run !== 1'b1) begin nFail++; $display("FAIL areset_pre: running %b want 1", run); end
        #2 rst = 1'b1;
        #1;
        nTests++; if (bcd !== 8'h00 || run !== 1'b0 || ovf !== 1'b0) begin nFail++; $display("FAIL areset_now: bcd %h run %b ovf %b want 00 0 0", bcd, run, ovf); end
        nTests++; if (seg !== {7'h3F, 7'h3F}) begin nFail++; $display("FAIL areset_seg: got %b", seg); end
        @(negedge clk); rst = 1'b0;
        ss = 1'b1;
        @(negedge clk); ss = 1'b0;
        @(negedge clk);
        nTests++; if (run !== 1'b0) begin nFail++; $display("FAIL areset_press_e2: running %b want 0", run); end
        @(negedge clk);
        nTests++; if (run !== 1'b1) begin nFail++; $display("FAIL areset_press_e3: running %b want 1", run); end
    endtask

    task automatic test_random();
        logic [7:0] e;
        for (int c = 0; c < 3600; c++) begin
            @(negedge clk);
            e = expBcd();
            nTests++; if (bcd !== e) begin nFail++; $display("FAIL rnd_bcd: cycle %0d got %h want %h", c, bcd, e); end
            nTests++; if (run !== mRun) begin nFail++; $display("FAIL rnd_running: cycle %0d got %b want %b", c, run, mRun); end
            nTests++; if (ovf !== mOvf) begin nFail++; $display("FAIL rnd_ovf: cycle %0d got %b want %b", c, ovf, mOvf); end
            nTests++; if (seg !== expSeg(e, 1'b1)) begin nFail++; $display("FAIL rnd_seg: cycle %0d got %b want %b", c, seg, expSeg(e, 1'b1)); end
            nTests++; if (segN !== expSeg(e, 1'b0) || bcdN !== e) begin nFail++; $display("FAIL rnd_pol0: cycle %0d seg %b bcd %h want %b %h", c, segN, bcdN, expSeg(e, 1'b0), e); end
            if (c < 1600) begin
                if ($urandom_range(0, 29) == 0) ss = ~ss;
                if ($urandom_range(0, 19) == 0) lp = ~lp;
                cl = ($urandom_range(0, 299) == 0);
            end else begin
                if ($urandom_range(0, 699) == 0) ss = ~ss;
                if ($urandom_range(0, 99) == 0) lp = ~lp;
                cl = ($urandom_range(0, 1999) == 0);
            end
        end
        ss = 1'b0; lp = 1'b0; cl = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", nTests, nFail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_start();
        test_carry_wrap();
        test_lap();
        test_stop_resume();
        test_priority();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Parametrised stopwatch core: a clock prescaler, start/stop/lap/clear control FSM and an N-digit cascaded BCD counter with per-digit 7-segment outputs. It extends the free-running 8-bit hex chronometer with these features:
- decimal digits;
- a configurable number of digits and tick period;
- button control with synchronisation and edge detection;
- a frozen lap display;
- a sticky overflow flag.

It sits between the board clock, the debounced push-buttons and the 7-segment displays.

## Interface
- CLK_DIV, 500000: ClkIn cycles per count tick (100 ms at 5 MHz); ≥2.
- NB_DIGITS, 4: number of BCD decades; digit 0 is the least significant (tenths of a second).
- SEG_POL, 1: segment active level; 1 = active-high, 0 = active-low.
- ClkIn  input  1  system clock; all logic on its rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- StartStop  input  1  debounced button, asynchronous to ClkIn.
- Lap  input  1  debounced button, asynchronous to ClkIn.
- Clear  input  1  debounced button, asynchronous to ClkIn.
- Bcd  output  4*NB_DIGITS  displayed value; digit i occupies Bcd[4i+3:4i].
- Seg  output  7*NB_DIGITS  7-segment code of the displayed digits; digit i occupies Seg[7i+6:7i], bit 7i = segment a through bit 7i+6 = segment g.
- Running  output  1  high in the RUN and LAP states.
- Ovf  output  1  sticky wrap-around flag.

## Operation
Button conditioning:
- Each button goes through a 3-flop chain s1 → s2 → s3.
- The internal press pulse is s2 & ~s3, one cycle wide per rising edge.
- Holding a button produces exactly one press.

Prescaler:
- Counts 0..CLK_DIV-1 only while in RUN or LAP, and holds its value in STOP.
- Tick = (count == CLK_DIV-1) while counting; the counter then returns to 0.

Counter:
- On a tick, digit 0 increments.
- Digit i at 9 that receives a carry returns to 0 and carries into digit i+1.
- When all digits are 9 and a tick occurs, all digits become 0 and Ovf is set to 1. Ovf stays 1 until Clear or Rst.

FSM states are IDLE, RUN, STOP and LAP. Press priority when presses coincide: Clear > StartStop > Lap.
- Clear, from any state → IDLE; counter, prescaler, lap latch and Ovf are zeroed.
- StartStop: IDLE → RUN; RUN → STOP; STOP → RUN; LAP → STOP, which releases the lap freeze.
- Lap: RUN → LAP, latching the current counter into the lap register; LAP → RUN, releasing the freeze.
- Lap presses in IDLE and STOP are ignored.

Display:
- Bcd = lap register in LAP, live counter otherwise.
- The counter keeps counting during LAP.
- Seg is the combinational decode of Bcd, using the digits 0-9 standard patterns. Codes 10-15 are unreachable and must decode to all segments off.
- When SEG_POL = 0, every Seg bit is inverted.

## Timing
Reset values:
- State IDLE.
- Counter, prescaler, lap register and Bcd all 0.
- Seg = pattern "0" on every digit: abcdef on, g off, at SEG_POL level.
- Running 0, Ovf 0, sync flops 0.

Press latency:
- Button high before edge 1 → s2 = 1 after edge 2 → state and registers update at edge 3.
- Running changes right after edge 3.

Counting latency:
- Entering RUN from IDLE at edge E makes the first tick occur at edge E+CLK_DIV, so Bcd = 1 after that edge.
- STOP → RUN resumes from the held prescaler value, so no time is lost or gained.

Simultaneous events:
- A tick coinciding with a StartStop press that leaves RUN is counted.
- A tick coinciding with a Lap press entering LAP: the lap register latches the pre-increment value.
- A tick coinciding with Clear: Clear wins and everything becomes 0.
- Ovf sets on the same edge the digits wrap.

Rst asserted mid-count clears everything immediately (asynchronous). The first press after Rst deasserts follows the 3-edge rule.

## Test plan
All scenarios use CLK_DIV=4, NB_DIGITS=2, SEG_POL=1.
- Reset: Rst high → Bcd=0x00, Seg=7'b0111111 per digit (a=bit0), Running=0, Ovf=0. Press StartStop → Running=1 at edge 3 after press; Bcd=0x01 after 4 more edges.
- Carry and wrap: run 99 ticks → Bcd=0x99, Ovf=0; next tick → Bcd=0x00, Ovf=1. Clear → Ovf=0, Bcd=0x00, state IDLE.
- Lap: at Bcd=0x12 press Lap → Bcd frozen at 0x12 while internal count advances 5 ticks. Press Lap → Bcd=0x17.
- Stop/resume precision: stop 2 cycles after a tick, idle 50 cycles, restart → next tick exactly 2 cycles after the state returns to RUN.
- Priority: Clear and StartStop pressed in the same cycle while in RUN → IDLE, Bcd=0x00, Running=0. Lap held high for 20 cycles → only one RUN↔LAP toggle.
- Polarity: rerun the reset scenario with SEG_POL=0 → Seg=7'b1000000 per digit.
